// File: rtl/div_result_pkg.sv
// Shared types, widths and the BCD nibble correction for the divider result stage.
package div_result_pkg;

  localparam int N_BITS   = 7;
  localparam int N_DIGITS = 3;
  localparam int BCD_W    = 4 * N_DIGITS;
  localparam int SCR_W    = BCD_W + N_BITS;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_Q = 2'd1,
    CONV_R = 2'd2,
    UPDATE = 2'd3
  } state_e;

  // Double-dabble pre-shift correction: a digit of 5 or more would carry
  // past 9 after doubling, so bias it by 3 first.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// One-iteration-per-clock binary to BCD converter (shift-add-3).
// load primes the scratch register with a fresh operand; each step applies
// the digit correction and shifts. bcd_out is the digit field as it will
// stand after the current step, so the caller can capture the final value
// on the same edge the last step would land.
module bin2bcd_iter
  import div_result_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [N_BITS-1:0] bin_in,
  output logic [BCD_W-1:0]  bcd_out,
  output logic              last
);

  logic [SCR_W-1:0] scr_q, scr_d;
  logic [SCR_W-1:0] adj;
  logic [SCR_W-1:0] shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Correct every BCD digit, then shift {bcd, bin} left by one.
  always_comb begin
    adj = scr_q;
    for (int d = 0; d < N_DIGITS; d++) begin
      adj[N_BITS + 4*d +: 4] = add3(scr_q[N_BITS + 4*d +: 4]);
    end
    shifted = adj << 1;
  end

  assign bcd_out = shifted[SCR_W-1:N_BITS];
  assign last    = (cnt_q == CNT_W'(N_BITS - 1));

  // Load takes priority so the caller can finish one operand and start the next together.
  always_comb begin
    scr_d = scr_q;
    cnt_d = cnt_q;
    if (load) begin
      scr_d = {{BCD_W{1'b0}}, bin_in};
      cnt_d = '0;
    end else if (step) begin
      scr_d = shifted;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Scratch and iteration counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scr_q <= '0;
      cnt_q <= '0;
    end else begin
      scr_q <= scr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div_result_bcd.sv
// Captures a divider result on the rising edge of done_in and converts the
// quotient and remainder to packed BCD {hundreds, tens, units}.
//
// state  | meaning
// IDLE   | waiting for a done_in rising edge; outputs hold last result
// CONV_Q | converting the quotient, one bit per clock
// CONV_R | converting the remainder, one bit per clock
// UPDATE | publishing both results, raising valid
module div_result_bcd #(
  parameter int N_BITS   = 7,
  parameter int N_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_in,
  input  logic [N_BITS-1:0]     Q_in,
  input  logic [N_BITS-1:0]     R_in,
  output logic [4*N_DIGITS-1:0] Q_bcd,
  output logic [4*N_DIGITS-1:0] R_bcd,
  output logic                  busy,
  output logic                  valid
);

  import div_result_pkg::*;

  localparam int OUT_W = 4 * N_DIGITS;

  state_e            state_q, state_d;
  logic              done_dly_q;
  logic [N_BITS-1:0] r_hold_q, r_hold_d;
  logic [OUT_W-1:0]  q_res_q, q_res_d;
  logic [OUT_W-1:0]  r_res_q, r_res_d;
  logic [OUT_W-1:0]  q_bcd_q, q_bcd_d;
  logic [OUT_W-1:0]  r_bcd_q, r_bcd_d;
  logic              valid_q, valid_d;

  logic              trig;
  logic              conv_load;
  logic              conv_step;
  logic [N_BITS-1:0] conv_bin;
  logic [OUT_W-1:0]  conv_bcd;
  logic              conv_last;

  assign trig = done_in & ~done_dly_q;

  // The quotient goes straight into the converter's binary field at the
  // trigger edge, which doubles as its hold register; the remainder is held
  // here until the quotient pass finishes.
  assign conv_bin = (state_q == IDLE) ? Q_in : r_hold_q;

  bin2bcd_iter u_conv (
    .clk     (clk),
    .rst     (rst),
    .load    (conv_load),
    .step    (conv_step),
    .bin_in  (conv_bin),
    .bcd_out (conv_bcd),
    .last    (conv_last)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    r_hold_d  = r_hold_q;
    q_res_d   = q_res_q;
    r_res_d   = r_res_q;
    q_bcd_d   = q_bcd_q;
    r_bcd_d   = r_bcd_q;
    valid_d   = valid_q;
    conv_load = 1'b0;
    conv_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          r_hold_d  = R_in;
          conv_load = 1'b1;
          valid_d   = 1'b0;
          state_d   = CONV_Q;
        end
      end
      CONV_Q: begin
        conv_step = 1'b1;
        if (conv_last) begin
          q_res_d   = conv_bcd;
          conv_load = 1'b1;
          state_d   = CONV_R;
        end
      end
      CONV_R: begin
        conv_step = 1'b1;
        if (conv_last) begin
          r_res_d = conv_bcd;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        q_bcd_d = q_res_q;
        r_bcd_d = r_res_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, edge detector and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      done_dly_q <= 1'b0;
      r_hold_q   <= '0;
      q_res_q    <= '0;
      r_res_q    <= '0;
      q_bcd_q    <= '0;
      r_bcd_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_dly_q <= done_in;
      r_hold_q   <= r_hold_d;
      q_res_q    <= q_res_d;
      r_res_q    <= r_res_d;
      q_bcd_q    <= q_bcd_d;
      r_bcd_q    <= r_bcd_d;
      valid_q    <= valid_d;
    end
  end

  assign Q_bcd = q_bcd_q;
  assign R_bcd = r_bcd_q;
  assign busy  = (state_q != IDLE);
  assign valid = valid_q;

endmodule
